// File: rtl/gcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gcd_pkg
// Brief    : Shared types and constants for the multi-requester GCD scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package gcd_pkg;

    localparam int GCD_DEF_W = 16;

    // Subtractor minuend select: 1 picks register A, 0 picks register B
    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LDA  = 3'd1,
        LDB  = 3'd2,
        RUN  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/gcd_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : gcd_rr_arb
// Brief    : Combinational round-robin pick of the first requester after ptr.
// Revision : 1.0 - initial release
// ============================================================================
module gcd_rr_arb
    import gcd_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [$clog2(NREQ)-1:0] gnt_idx,
    output logic                    gnt_any
);

    localparam int c_IW = $clog2(NREQ);

    logic [c_IW-1:0] w_idx;

    // Scan from farthest to nearest so the nearest requester after ptr wins
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        w_idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = c_IW'((int'(ptr) + k) % NREQ);
            if (req[w_idx]) begin
                gnt_idx = w_idx;
                gnt_any = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gcd_sched.sv
`default_nettype none
// ============================================================================
// Module   : gcd_sched
// Brief    : Round-robin scheduler sharing one subtractive GCD datapath.
//            Define GCD_TIMEOUT_EN to add a MAX_ITER limit on RUN cycles.
// Revision : 1.0 - initial release
// ============================================================================
module gcd_sched
    import gcd_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int W        = GCD_DEF_W,
    parameter int MAX_ITER = 65536
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*W-1:0]       opa,
    input  logic [NREQ*W-1:0]       opb,
    output logic [NREQ-1:0]         ack,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [W-1:0]            rsp_data,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    dp_ldA,
    output logic                    dp_ldB,
    output logic                    dp_sel_in,
    output logic                    dp_sel1,
    output logic                    dp_sel2,
    output logic [W-1:0]            dp_data_in,
    input  logic                    dp_lt,
    input  logic                    dp_gt,
    input  logic                    dp_eq,
    input  logic [W-1:0]            dp_aout
);

    localparam int c_IW = $clog2(NREQ);

    logic [W-1:0]    w_opa [NREQ];
    logic [W-1:0]    w_opb [NREQ];

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_IW-1:0] r_gnt_id;
    logic [c_IW-1:0] r_ptr;
    logic            r_byp;
    logic [W-1:0]    r_byp_data;

    logic [c_IW-1:0] w_arb_idx;
    logic            w_arb_any;
    logic            w_arb_zero;
    logic [W-1:0]    w_arb_byp;
    logic            w_timeout;
    logic            w_err;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_opa[gi] = opa[gi*W +: W];
        assign w_opb[gi] = opb[gi*W +: W];
    end

    gcd_rr_arb #(
        .NREQ    (NREQ)
    ) u_arb (
        .req     (req),
        .ptr     (r_ptr),
        .gnt_idx (w_arb_idx),
        .gnt_any (w_arb_any)
    );

    // A zero operand makes the answer the other operand, with gcd(0,0) = 0
    assign w_arb_zero = (w_opa[w_arb_idx] == '0) || (w_opb[w_arb_idx] == '0);
    assign w_arb_byp  = (w_opa[w_arb_idx] == '0) ? w_opb[w_arb_idx] : w_opa[w_arb_idx];

`ifdef GCD_TIMEOUT_EN
    localparam int              c_CW  = $clog2(MAX_ITER + 1);
    localparam logic [c_CW-1:0] c_MAX = c_CW'(MAX_ITER);

    logic [c_CW-1:0] r_cnt;
    logic            r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == LDB) begin
                r_cnt <= '0;
            end else if (r_state == RUN) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == IDLE && w_arb_any) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign w_timeout = (r_state == RUN) && !dp_eq && (r_cnt == c_MAX);
    assign w_err     = r_err;
`else
    logic w_unused_max_iter;
    assign w_unused_max_iter = (MAX_ITER > 0);
    assign w_timeout         = 1'b0;
    assign w_err             = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_gnt_id   <= '0;
            r_ptr      <= c_IW'(NREQ - 1);
            r_byp      <= 1'b0;
            r_byp_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_arb_any) begin
                r_gnt_id   <= w_arb_idx;
                r_ptr      <= w_arb_idx;
                r_byp      <= w_arb_zero;
                r_byp_data <= w_arb_byp;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_arb_any) w_state_nxt = w_arb_zero ? DONE : LDA;
            LDA:     w_state_nxt = LDB;
            LDB:     w_state_nxt = RUN;
            RUN:     if (dp_eq || w_timeout) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ack        = '0;
        rsp_valid  = 1'b0;
        rsp_id     = '0;
        rsp_data   = '0;
        rsp_err    = 1'b0;
        busy       = (r_state != IDLE);
        dp_ldA     = 1'b0;
        dp_ldB     = 1'b0;
        dp_sel_in  = 1'b0;
        dp_sel1    = 1'b0;
        dp_sel2    = 1'b0;
        dp_data_in = '0;
        case (r_state)
            LDA: begin
                dp_data_in = w_opa[r_gnt_id];
                dp_sel_in  = 1'b1;
                dp_ldA     = 1'b1;
            end
            LDB: begin
                dp_data_in = w_opb[r_gnt_id];
                dp_sel_in  = 1'b1;
                dp_ldB     = 1'b1;
            end
            RUN: begin
                // Subtrahend select has the opposite sense: 1 picks B
                if (!dp_eq && !w_timeout) begin
                    if (dp_gt) begin
                        dp_sel1 = SEL_A;
                        dp_sel2 = ~SEL_B;
                        dp_ldA  = 1'b1;
                    end else if (dp_lt) begin
                        dp_sel1 = SEL_B;
                        dp_sel2 = ~SEL_A;
                        dp_ldB  = 1'b1;
                    end
                end
            end
            DONE: begin
                for (int i = 0; i < NREQ; i++) begin
                    ack[i] = (r_gnt_id == c_IW'(i));
                end
                rsp_valid = 1'b1;
                rsp_id    = r_gnt_id;
                rsp_err   = w_err;
                if (r_byp) begin
                    rsp_data = r_byp_data;
                end else if (!w_err) begin
                    rsp_data = dp_aout;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_gcd_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_sched
// Brief    : Self-checking bench for gcd_sched with a datapath and job model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_sched;

    localparam int NREQ   = 4;
    localparam int W      = 16;
    localparam int IW     = 2;
    localparam int TB_MAX = 8;
`ifdef GCD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] opa;
    logic [NREQ*W-1:0] opb;
    logic [NREQ-1:0]   ack;
    logic              rsp_valid;
    logic [IW-1:0]     rsp_id;
    logic [W-1:0]      rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              dp_ldA, dp_ldB, dp_sel_in, dp_sel1, dp_sel2;
    logic [W-1:0]      dp_data_in;
    logic              dp_lt, dp_gt, dp_eq;
    logic [W-1:0]      dp_aout;

    always #5 clk = ~clk;

    gcd_sched #(
        .NREQ       (NREQ),
        .W          (W),
        .MAX_ITER   (TB_MAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .opa        (opa),
        .opb        (opb),
        .ack        (ack),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .dp_ldA     (dp_ldA),
        .dp_ldB     (dp_ldB),
        .dp_sel_in  (dp_sel_in),
        .dp_sel1    (dp_sel1),
        .dp_sel2    (dp_sel2),
        .dp_data_in (dp_data_in),
        .dp_lt      (dp_lt),
        .dp_gt      (dp_gt),
        .dp_eq      (dp_eq),
        .dp_aout    (dp_aout)
    );

    // Shared subtractive GCD datapath the scheduler drives
    logic [W-1:0] r_dpa, r_dpb, w_sub;
    assign w_sub   = (dp_sel1 ? r_dpa : r_dpb) - (dp_sel2 ? r_dpb : r_dpa);
    assign dp_lt   = (r_dpa < r_dpb);
    assign dp_gt   = (r_dpa > r_dpb);
    assign dp_eq   = (r_dpa == r_dpb);
    assign dp_aout = r_dpa;
    always @(posedge clk) begin
        if (dp_ldA) r_dpa <= dp_sel_in ? dp_data_in : w_sub;
        if (dp_ldB) r_dpb <= dp_sel_in ? dp_data_in : w_sub;
    end

    int     checks = 0;
    int     fails  = 0;
    longint cyc    = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ack"},   longint'(ack), 0);
        chk({tag, "_valid"}, longint'(rsp_valid), 0);
        chk({tag, "_data"},  longint'(rsp_data), 0);
        chk({tag, "_err"},   longint'(rsp_err), 0);
        chk({tag, "_busy"},  longint'(busy), 0);
        chk({tag, "_dpctl"}, longint'({dp_ldA, dp_ldB, dp_sel_in, dp_sel1, dp_sel2}), 0);
        chk({tag, "_dpin"},  longint'(dp_data_in), 0);
    endtask

    // Job outcome from the GCD rules: latency from grant, result and error flag
    function automatic void job(input logic [W-1:0] a, input logic [W-1:0] b,
                                output int lat, output logic [W-1:0] data, output bit err);
        int x, y, n;
        err = 1'b0;
        if (a == '0 || b == '0) begin
            lat  = 1;
            data = (a == '0) ? b : a;
            return;
        end
        x = int'(a);
        y = int'(b);
        n = 0;
        while (x != y) begin
            if (x > y) x -= y;
            else       y -= x;
            n++;
        end
        lat  = 4 + n;
        data = W'(x);
        if (TO_EN && n > TB_MAX) begin
            lat  = 4 + TB_MAX;
            data = '0;
            err  = 1'b1;
        end
    endfunction

    // Reference model state and per-cycle compare
    bit              m_busy;
    int              m_ptr, m_id, m_lat, m_idx;
    longint          m_done;
    logic [W-1:0]    m_data;
    bit              m_err;
    logic [NREQ-1:0] exp_ack;
    bit              exp_v;
    logic [NREQ-1:0] ack_prev;
    int              ack_log[$];

    initial begin
        m_busy   = 1'b0;
        m_ptr    = NREQ - 1;
        ack_prev = '0;
        forever begin
            @(negedge clk);
            cyc++;
            ack_prev = ack;
            if (!rst_n) begin
                chk_quiet("inrst");
                m_busy = 1'b0;
                m_ptr  = NREQ - 1;
            end else begin
                exp_ack = '0;
                exp_v   = 1'b0;
                if (m_busy && cyc == m_done) begin
                    exp_ack[m_id] = 1'b1;
                    exp_v         = 1'b1;
                end
                chk("ack",       longint'(ack), longint'(exp_ack));
                chk("rsp_valid", longint'(rsp_valid), longint'(exp_v));
                chk("busy",      longint'(busy), longint'(m_busy));
                if (exp_v) begin
                    chk("rsp_id",   longint'(rsp_id), m_id);
                    chk("rsp_data", longint'(rsp_data), longint'(m_data));
                    chk("rsp_err",  longint'(rsp_err), longint'(m_err));
                end
                if (rsp_valid) ack_log.push_back(int'(rsp_id));
                if (m_busy) begin
                    if (cyc == m_done) m_busy = 1'b0;
                end else begin
                    for (int k = 1; k <= NREQ; k++) begin
                        m_idx = (m_ptr + k) % NREQ;
                        if (req[m_idx[IW-1:0]]) begin
                            m_busy = 1'b1;
                            m_id   = m_idx;
                            m_ptr  = m_idx;
                            job(opa[m_idx*W +: W], opb[m_idx*W +: W], m_lat, m_data, m_err);
                            m_done = cyc + m_lat;
                            break;
                        end
                    end
                end
            end
        end
    end

    // Requester behaviour: drop the cycle after ack; optionally re-raise
    logic [NREQ-1:0] hold;
    bit              rnd_mode;

    function automatic logic [W-1:0] rnd_op();
        if ($urandom_range(0, 9) == 0) return '0;
        return W'($urandom_range(1, 255));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && ack_prev[i]) begin
                req[i] = 1'b0;
            end else if (!req[i] && (hold[i] || (rnd_mode && $urandom_range(0, 3) == 0))) begin
                if (rnd_mode) begin
                    opa[i*W +: W] = rnd_op();
                    opb[i*W +: W] = rnd_op();
                end
                req[i] = 1'b1;
            end
        end
    endtask

    task automatic raise(input int id, input int a, input int b, output longint t);
        opa[id*W +: W] = W'(a);
        opb[id*W +: W] = W'(b);
        req[id]        = 1'b1;
        t              = cyc + 1;
    endtask

    task automatic wait_ack(input int id, input int budget, input string name, output longint at);
        at = -1;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (ack[id]) begin
                at = cyc + 1;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            fails++;
            $display("FAIL %s: no ack[%0d] within %0d cycles, required one", name, id, budget);
        end
    endtask

    task automatic drain(input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (req == '0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: busy=%0b req=%b after %0d cycles, required idle", name, busy, req, budget);
        end
    endtask

    task automatic directed(input string name, input int id, input int a, input int b,
                            input int lat, input int data, input int err);
        longint t, at;
        drain(2000, {name, "_pre"});
        raise(id, a, b, t);
        wait_ack(id, lat + 40, name, at);
        if (at >= 0) begin
            chk({name, "_lat"},  at - t, lat);
            chk({name, "_data"}, longint'(rsp_data), data);
            chk({name, "_id"},   longint'(rsp_id), id);
            chk({name, "_err"},  longint'(rsp_err), err);
        end
    endtask

    int           exp_order[5] = '{0, 1, 2, 3, 0};
    int           pin_lat;
    logic [W-1:0] pin_data;
    bit           pin_err;
    int           base;
    longint       t_dummy;

    initial begin
        rst_n    = 1'b1;
        req      = '0;
        opa      = '0;
        opb      = '0;
        hold     = '0;
        rnd_mode = 1'b0;

        job(16'd143, 16'd78, pin_lat, pin_data, pin_err);
        chk("model_143_78_lat", pin_lat, 10);
        chk("model_143_78_data", longint'(pin_data), 13);
        job(16'd0, 16'd45, pin_lat, pin_data, pin_err);
        chk("model_byp_lat", pin_lat, 1);
        chk("model_byp_data", longint'(pin_data), 45);

        #2 rst_n = 1'b0;
        #1 chk_quiet("reset");
        repeat (3) tick();
        rst_n = 1'b1;

        // Fairness from the reset pointer with all four held
        for (int i = 0; i < NREQ; i++) begin
            opa[i*W +: W] = W'(i + 2);
            opb[i*W +: W] = W'(i + 2);
        end
        base = ack_log.size();
        hold = '1;
        for (int n = 0; n < 200 && ack_log.size() < base + 5; n++) tick();
        hold = '0;
        if (ack_log.size() < base + 5) begin
            checks++;
            fails++;
            $display("FAIL fair_order: %0d acks seen, required 5", ack_log.size() - base);
        end else begin
            for (int k = 0; k < 5; k++) chk($sformatf("fair_order%0d", k), ack_log[base + k], exp_order[k]);
        end

        directed("single", 0, 143, 78, 10, 13, 0);
        directed("equal",  2, 7, 7, 4, 7, 0);
        directed("byp",    1, 0, 45, 1, 45, 0);
        directed("byp00",  1, 0, 0, 1, 0, 0);
        directed("bypb0",  3, 36, 0, 1, 36, 0);
`ifdef GCD_TIMEOUT_EN
        directed("tmo",    3, 1000, 1, 4 + TB_MAX, 0, 1);
`endif

        // Reset in the middle of a long job, with another requester waiting
        drain(2000, "mrst_pre");
        tick();
        raise(1, 1000, 1, t_dummy);
        repeat (6) tick();
        raise(2, 7, 7, t_dummy);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_quiet("mrst");
        repeat (2) tick();
        tick();
        rst_n = 1'b1;
        base = ack_log.size();
        for (int n = 0; n < 1200 && ack_log.size() < base + 2; n++) tick();
        if (ack_log.size() < base + 2) begin
            checks++;
            fails++;
            $display("FAIL mrst_order: %0d acks seen, required 2", ack_log.size() - base);
        end else begin
            chk("mrst_first", ack_log[base], 1);
            chk("mrst_second", ack_log[base + 1], 2);
        end
        drain(2000, "mrst_post");

        rnd_mode = 1'b1;
        repeat (4000) tick();
        rnd_mode = 1'b0;
        drain(3000, "rnd_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
